// File: rtl/uart_rx_sequencer.sv
// Receive-instruction sequencer: pauses the PC, runs the UART RX datapath with an
// oversample tick and writes the received byte (or 0 on timeout) to the register file.
module uart_rx_sequencer #(
    parameter int          CLK_HZ        = 50000000,
    parameter int          BAUD          = 115200,
    parameter int          OVERSAMPLE    = 16,
    parameter logic [5:0]  OP_RX         = 6'd40,
    parameter logic [15:0] TIMEOUT_TICKS = 16'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [4:0] rd_sel,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic       rx_ferr,
    input  logic       clr_status,
    output logic       tick,
    output logic       rx_en,
    output logic       pc_pause,
    output logic       rf_we,
    output logic [4:0] rf_waddr,
    output logic [7:0] rf_wdata,
    output logic       rx_timeout,
    output logic       rx_frame_err
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT,
        ST_WRITE,
        ST_RELEASE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [DIV_W-1:0]  div_cnt;
    logic [15:0]       to_cnt;
    logic              timeout_hit;
    logic              rx_start;

    assign rx_start = (opcode == OP_RX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        tick        = 1'b0;
        rx_en       = 1'b0;
        pc_pause    = 1'b0;
        rf_we       = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_start) begin
                    pc_pause   = 1'b1;
                    next_state = ST_ARM;
                end
            end
            ST_ARM: begin
                rx_en      = 1'b1;
                pc_pause   = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                rx_en       = 1'b1;
                pc_pause    = 1'b1;
                tick        = (div_cnt == DIV_LAST);
                timeout_hit = (TIMEOUT_TICKS != 16'd0) && tick &&
                              (to_cnt == TIMEOUT_TICKS - 16'd1);
                if (rx_done || timeout_hit) begin
                    next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                pc_pause   = 1'b1;
                rf_we      = 1'b1;
                next_state = ST_RELEASE;
            end
            ST_RELEASE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // rx_done outranks a same-cycle timeout, so the timeout flag is only set without it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt      <= '0;
            to_cnt       <= 16'd0;
            rf_waddr     <= 5'd0;
            rf_wdata     <= 8'd0;
            rx_timeout   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (state == ST_WAIT) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end

            if (state == ST_ARM) begin
                to_cnt <= 16'd0;
            end else if (state == ST_WAIT && tick && TIMEOUT_TICKS != 16'd0) begin
                to_cnt <= to_cnt + 16'd1;
            end

            if (state == ST_IDLE && rx_start) begin
                rf_waddr <= rd_sel;
            end

            if (state == ST_WAIT && rx_done) begin
                rf_wdata <= rx_data;
            end else if (state == ST_WAIT && timeout_hit) begin
                rf_wdata <= 8'h00;
            end

            if (state == ST_WAIT && rx_done && rx_ferr) begin
                rx_frame_err <= 1'b1;
            end else if (clr_status) begin
                rx_frame_err <= 1'b0;
            end

            if (state == ST_WAIT && !rx_done && timeout_hit) begin
                rx_timeout <= 1'b1;
            end else if (clr_status) begin
                rx_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer at default clocking with a 200-tick timeout.
// Inputs change and outputs are sampled 1ns after each falling clock edge.
module tb_uart_rx_sequencer;

    localparam logic [5:0] OP_RX = 6'd40;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic [4:0] rd_sel;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rx_ferr;
    logic       clr_status;
    logic       tick;
    logic       rx_en;
    logic       pc_pause;
    logic       rf_we;
    logic [4:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       rx_timeout;
    logic       rx_frame_err;

    int vectors     = 0;
    int miscompares = 0;
    int we_count    = 0;

    uart_rx_sequencer #(.TIMEOUT_TICKS(16'd200)) dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .rd_sel      (rd_sel),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .rx_ferr     (rx_ferr),
        .clr_status  (clr_status),
        .tick        (tick),
        .rx_en       (rx_en),
        .pc_pause    (pc_pause),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rx_timeout  (rx_timeout),
        .rx_frame_err(rx_frame_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (rf_we) we_count++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task step();
        @(negedge clock);
        #1;
    endtask

    task steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task test_reset();
        int ticks;
        reset = 1'b0; opcode = 6'd0; rd_sel = 5'd0; rx_done = 1'b0;
        rx_data = 8'd0; rx_ferr = 1'b0; clr_status = 1'b0;
        #1;
        vectors++; if ({tick, rx_en, pc_pause, rf_we, rf_waddr, rf_wdata, rx_timeout, rx_frame_err} !== 19'd0) begin miscompares++; $display("[TB] FAIL reset_outputs: got %h expected 0", {tick, rx_en, pc_pause, rf_we, rf_waddr, rf_wdata, rx_timeout, rx_frame_err}); end
        step();
        reset = 1'b1;
        step();
        rx_done = 1'b1; rx_data = 8'hFF;
        step();
        rx_done = 1'b0; rx_data = 8'h00;
        ticks = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (tick) ticks++;
        end
        vectors++; if (we_count !== 0) begin miscompares++; $display("[TB] FAIL idle_rx_done_write: got %0d writes expected 0", we_count); end
        vectors++; if (rf_wdata !== 8'h00) begin miscompares++; $display("[TB] FAIL idle_rx_done_wdata: got %h expected 00", rf_wdata); end
        vectors++; if (ticks !== 0) begin miscompares++; $display("[TB] FAIL idle_ticks: got %0d expected 0", ticks); end
    endtask

    task test_normal_receive();
        int base;
        base = we_count;
        opcode = OP_RX; rd_sel = 5'd5;
        #1;
        vectors++; if (pc_pause !== 1'b1) begin miscompares++; $display("[TB] FAIL same_cycle_pause: got %b expected 1", pc_pause); end
        step();
        vectors++; if ({rx_en, pc_pause} !== 2'b11) begin miscompares++; $display("[TB] FAIL arm_en_pause: got %b expected 11", {rx_en, pc_pause}); end
        steps(2999);
        rx_done = 1'b1; rx_data = 8'hA5;
        step();
        rx_done = 1'b0; rx_data = 8'h00;
        vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("[TB] FAIL normal_we: got %b expected 1", rf_we); end
        vectors++; if (rf_waddr !== 5'd5) begin miscompares++; $display("[TB] FAIL normal_waddr: got %0d expected 5", rf_waddr); end
        vectors++; if (rf_wdata !== 8'hA5) begin miscompares++; $display("[TB] FAIL normal_wdata: got %h expected a5", rf_wdata); end
        vectors++; if (rx_en !== 1'b0) begin miscompares++; $display("[TB] FAIL write_rx_en: got %b expected 0", rx_en); end
        step();
        vectors++; if ({pc_pause, rf_we} !== 2'b00) begin miscompares++; $display("[TB] FAIL release_pause_we: got %b expected 00", {pc_pause, rf_we}); end
        opcode = 6'd0;
        step();
        vectors++; if (we_count - base !== 1) begin miscompares++; $display("[TB] FAIL normal_we_pulses: got %0d expected 1", we_count - base); end
        vectors++; if (rf_wdata !== 8'hA5) begin miscompares++; $display("[TB] FAIL wdata_held: got %h expected a5", rf_wdata); end
        vectors++; if ({rx_timeout, rx_frame_err} !== 2'b00) begin miscompares++; $display("[TB] FAIL normal_flags: got %b expected 00", {rx_timeout, rx_frame_err}); end
    endtask

    task test_tick_spacing();
        int t [3];
        int n;
        n = 0;
        t[0] = 0; t[1] = 0; t[2] = 0;
        opcode = OP_RX; rd_sel = 5'd6;
        // c=1 is the ARM cycle, c=2 the first WAIT cycle
        for (int c = 1; c <= 90; c++) begin
            step();
            if (tick) begin
                if (n < 3) t[n] = c;
                n++;
            end
        end
        vectors++; if (t[0] - 1 !== 27) begin miscompares++; $display("[TB] FAIL first_tick_wait_cycle: got %0d expected 27", t[0] - 1); end
        vectors++; if (t[1] - t[0] !== 27) begin miscompares++; $display("[TB] FAIL tick_spacing_1: got %0d expected 27", t[1] - t[0]); end
        vectors++; if (t[2] - t[1] !== 27) begin miscompares++; $display("[TB] FAIL tick_spacing_2: got %0d expected 27", t[2] - t[1]); end
        vectors++; if (n !== 3) begin miscompares++; $display("[TB] FAIL tick_count: got %0d expected 3", n); end
        rx_done = 1'b1; rx_data = 8'h5A;
        step();
        rx_done = 1'b0;
        vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd6, 8'h5A}) begin miscompares++; $display("[TB] FAIL spacing_write: got %h expected %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd6, 8'h5A}); end
        step();
        opcode = 6'd0;
        step();
    endtask

    task test_timeout();
        int  ticks;
        bit  seen;
        ticks = 0; seen = 1'b0;
        opcode = OP_RX; rd_sel = 5'd9;
        for (int c = 0; c < 6000 && !seen; c++) begin
            step();
            if (rf_we) seen = 1'b1;
            else if (tick) ticks++;
        end
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_write_seen: got %b expected 1", seen); end
        vectors++; if (ticks !== 200) begin miscompares++; $display("[TB] FAIL timeout_ticks: got %0d expected 200", ticks); end
        vectors++; if ({rf_waddr, rf_wdata} !== {5'd9, 8'h00}) begin miscompares++; $display("[TB] FAIL timeout_write: got %h expected %h", {rf_waddr, rf_wdata}, {5'd9, 8'h00}); end
        vectors++; if (rx_timeout !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_flag_set: got %b expected 1", rx_timeout); end
        step();
        opcode = 6'd0;
        steps(10);
        vectors++; if (rx_timeout !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_sticky: got %b expected 1", rx_timeout); end
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        vectors++; if (rx_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_clear: got %b expected 0", rx_timeout); end
    endtask

    task test_frame_error();
        vectors++; if (rx_frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL ferr_initial: got %b expected 0", rx_frame_err); end
        opcode = OP_RX; rd_sel = 5'd3;
        steps(100);
        // clr_status coincides with the set; the set must win
        rx_done = 1'b1; rx_ferr = 1'b1; rx_data = 8'h3C; clr_status = 1'b1;
        step();
        rx_done = 1'b0; rx_ferr = 1'b0; rx_data = 8'h00; clr_status = 1'b0;
        vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 8'h3C}) begin miscompares++; $display("[TB] FAIL ferr_write: got %h expected %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd3, 8'h3C}); end
        vectors++; if (rx_frame_err !== 1'b1) begin miscompares++; $display("[TB] FAIL ferr_set_wins: got %b expected 1", rx_frame_err); end
        step();
        opcode = 6'd0;
        step();
        vectors++; if (rx_frame_err !== 1'b1) begin miscompares++; $display("[TB] FAIL ferr_sticky: got %b expected 1", rx_frame_err); end
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        vectors++; if (rx_frame_err !== 1'b0) begin miscompares++; $display("[TB] FAIL ferr_clear: got %b expected 0", rx_frame_err); end
    endtask

    task test_simultaneous();
        int ticks;
        bit seen;
        ticks = 0; seen = 1'b0;
        opcode = OP_RX; rd_sel = 5'd7;
        for (int c = 0; c < 6000 && !seen; c++) begin
            step();
            if (tick) begin
                ticks++;
                if (ticks == 200) begin
                    rx_done = 1'b1; rx_data = 8'h81;
                    seen = 1'b1;
                end
            end
        end
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("[TB] FAIL simul_200th_tick: got %b expected 1", seen); end
        step();
        rx_done = 1'b0; rx_data = 8'h00;
        vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 8'h81}) begin miscompares++; $display("[TB] FAIL simul_write: got %h expected %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd7, 8'h81}); end
        vectors++; if (rx_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_timeout_flag: got %b expected 0", rx_timeout); end
        step();
        opcode = 6'd0;
        step();
    endtask

    task test_back_to_back();
        int base;
        base = we_count;
        opcode = OP_RX; rd_sel = 5'd1;
        steps(21);
        rx_done = 1'b1; rx_data = 8'h11;
        step();
        rx_done = 1'b0; rx_data = 8'h00;
        vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 8'h11}) begin miscompares++; $display("[TB] FAIL b2b_first_write: got %h expected %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd1, 8'h11}); end
        rd_sel = 5'd2;
        step();
        vectors++; if ({pc_pause, rf_we} !== 2'b00) begin miscompares++; $display("[TB] FAIL b2b_release: got %b expected 00", {pc_pause, rf_we}); end
        step();
        vectors++; if ({pc_pause, rx_en, rf_waddr} !== {1'b1, 1'b0, 5'd1}) begin miscompares++; $display("[TB] FAIL b2b_idle_accept: got %h expected %h", {pc_pause, rx_en, rf_waddr}, {1'b1, 1'b0, 5'd1}); end
        step();
        vectors++; if ({rx_en, rf_waddr} !== {1'b1, 5'd2}) begin miscompares++; $display("[TB] FAIL b2b_arm: got %h expected %h", {rx_en, rf_waddr}, {1'b1, 5'd2}); end
        // a pulse during ARM must be ignored
        rx_done = 1'b1; rx_data = 8'hFF;
        step();
        rx_done = 1'b0; rx_data = 8'h00;
        vectors++; if ({rf_we, rx_en, rf_wdata} !== {1'b0, 1'b1, 8'h11}) begin miscompares++; $display("[TB] FAIL arm_rx_done_ignored: got %h expected %h", {rf_we, rx_en, rf_wdata}, {1'b0, 1'b1, 8'h11}); end
        steps(30);
        rx_done = 1'b1; rx_data = 8'h22;
        step();
        rx_done = 1'b0; rx_data = 8'h00;
        vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd2, 8'h22}) begin miscompares++; $display("[TB] FAIL b2b_second_write: got %h expected %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd2, 8'h22}); end
        step();
        opcode = 6'd0;
        step();
        vectors++; if (we_count - base !== 2) begin miscompares++; $display("[TB] FAIL b2b_we_pulses: got %0d expected 2", we_count - base); end
    endtask

    task test_reset_mid_wait();
        int base;
        base = we_count;
        opcode = OP_RX; rd_sel = 5'd12;
        steps(50);
        reset = 1'b0; opcode = 6'd0; rx_done = 1'b1; rx_data = 8'hEE;
        #1;
        vectors++; if ({tick, rx_en, pc_pause, rf_we, rf_waddr, rf_wdata, rx_timeout, rx_frame_err} !== 19'd0) begin miscompares++; $display("[TB] FAIL midwait_reset_outputs: got %h expected 0", {tick, rx_en, pc_pause, rf_we, rf_waddr, rf_wdata, rx_timeout, rx_frame_err}); end
        step();
        rx_done = 1'b0; rx_data = 8'h00;
        step();
        reset = 1'b1;
        step();
        vectors++; if (we_count !== base) begin miscompares++; $display("[TB] FAIL midwait_no_write: got %0d writes expected %0d", we_count, base); end
        vectors++; if ({rf_we, rf_wdata, pc_pause} !== 10'd0) begin miscompares++; $display("[TB] FAIL midwait_after_release: got %h expected 0", {rf_we, rf_wdata, pc_pause}); end
        opcode = OP_RX; rd_sel = 5'd4;
        step();
        vectors++; if (rx_en !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_arm: got %b expected 1", rx_en); end
        steps(40);
        rx_done = 1'b1; rx_data = 8'h77;
        step();
        rx_done = 1'b0; rx_data = 8'h00;
        vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 8'h77}) begin miscompares++; $display("[TB] FAIL post_reset_write: got %h expected %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd4, 8'h77}); end
        step();
        opcode = 6'd0;
        step();
        vectors++; if (we_count - base !== 1) begin miscompares++; $display("[TB] FAIL post_reset_pulses: got %0d expected 1", we_count - base); end
    endtask

    initial begin
        test_reset();
        test_normal_receive();
        test_tick_spacing();
        test_timeout();
        test_frame_error();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_sequencer.md
UART_RX_SEQUENCER -- requirements
Module: uart_rx_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, ticks per bit.
REQ-004 SHALL have parameter OP_RX, default 6'd40, opcode of the receive instruction.
REQ-005 SHALL have parameter TIMEOUT_TICKS, default 16'd0, tick count before abort; 0 disables the timeout.
REQ-006 SHALL have port clock  in  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port opcode  in  6  current instruction opcode from the control unit.
REQ-009 SHALL have port rd_sel  in  5  destination register index of the current instruction.
REQ-010 SHALL have port rx_done  in  1  one-cycle pulse from the RX datapath: byte complete.
REQ-011 SHALL have port rx_data  in  8  received byte; valid when rx_done=1.
REQ-012 SHALL have port rx_ferr  in  1  stop-bit error; valid when rx_done=1.
REQ-013 SHALL have port clr_status  in  1  clears the sticky status flags.
REQ-014 SHALL have port tick  out  1  one-cycle oversample pulse to the RX datapath.
REQ-015 SHALL have port rx_en  out  1  RX datapath enable.
REQ-016 SHALL have port pc_pause  out  1  holds the PC while a receive is in progress.
REQ-017 SHALL have port rf_we, rf_waddr, rf_wdata  out  1/5/8  register-file write port.
REQ-018 SHALL have port rx_timeout, rx_frame_err  out  1/1  sticky status flags.

Function
REQ-019 SHALL compute divisor DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer-truncated with minimum 1 (27 at defaults).
REQ-020 SHALL run the tick divider only in WAIT: it counts 0..DIV-1 and pulses tick for 1 cycle at DIV-1; the count is held at 0 in all other states, so the first tick comes DIV cycles after WAIT entry.
REQ-021 SHALL implement the FSM IDLE -> ARM -> WAIT -> WRITE -> RELEASE -> IDLE, with each state other than WAIT lasting exactly 1 cycle.
REQ-022 SHALL, in IDLE with opcode==OP_RX, capture rd_sel into rf_waddr and go to ARM; other opcodes stay in IDLE.
REQ-023 SHALL drive pc_pause combinationally: 1 in ARM/WAIT/WRITE, and in IDLE when opcode==OP_RX (same-cycle pause); 0 in RELEASE.
REQ-024 SHALL, in ARM, clear the timeout counter and the divider and assert rx_en, which stays asserted through WAIT.
REQ-025 SHALL, in WAIT on rx_done, latch rx_data into rf_wdata, set rx_frame_err if rx_ferr=1 (the byte is still written), and go to WRITE.
REQ-026 SHALL, in WAIT when TIMEOUT_TICKS!=0, increment the timeout counter on each tick; on reaching TIMEOUT_TICKS it sets rx_timeout, loads rf_wdata=8'h00 and goes to WRITE.
REQ-027 SHALL give rx_done priority when rx_done and timeout expiry occur in the same cycle; rx_timeout is then not set.
REQ-028 SHALL, in WRITE, assert rf_we for exactly 1 cycle with rx_en=0, giving a rf_we latency of 1 cycle after rx_done.
REQ-029 SHALL, in RELEASE, ignore opcode so the held instruction cannot retrigger; a back-to-back receive is accepted in the following IDLE cycle.
REQ-030 SHALL ignore rx_done outside WAIT.
REQ-031 SHALL keep rx_timeout and rx_frame_err set until clr_status=1; when a set and clr_status coincide, set wins.
REQ-032 SHALL hold rf_waddr and rf_wdata stable between receives.

Reset
REQ-033 SHALL, on reset=0, immediately (asynchronously) enter IDLE and force tick=0, rx_en=0, rf_we=0, rf_waddr=0, rf_wdata=0, rx_timeout=0, rx_frame_err=0, and clear the divider and timeout counter.
REQ-034 SHALL, when reset is asserted mid-receive, drop pc_pause at once (unless opcode==OP_RX in IDLE), perform no register write, and ignore any pending rx_done.

Verification
REQ-035 SHALL be verified for normal receive: opcode=40, rd_sel=5, rx_done with rx_data=8'hA5 after 3000 cycles -> a single rf_we pulse 1 cycle later with waddr=5, wdata=A5, and pc_pause=0 in the following cycle.
REQ-036 SHALL be verified for tick spacing at defaults: consecutive tick pulses are 27 cycles apart, the first 27 cycles after WAIT entry, and no ticks occur in IDLE.
REQ-037 SHALL be verified for timeout with TIMEOUT_TICKS=200 and no rx_done: rf_we with wdata=00 after 200 ticks, rx_timeout=1 until clr_status.
REQ-038 SHALL be verified for frame error: rx_done with rx_ferr=1 and data 8'h3C -> wdata=3C written and rx_frame_err=1.
REQ-039 SHALL be verified for a simultaneous rx_done and timeout expiry: data written and rx_timeout=0.
REQ-040 SHALL be verified for reset mid-WAIT: all outputs reach reset values with no rf_we, and a later opcode=40 is accepted normally.
